cam_key_scan: RTL
=================

Name: cam_key_scan

Overview:
- Consumer stage directly downstream of the OV7670 camera frame buffer.
- Raster-scans a configurable band of rows through the buffer's synchronous read port (addr -> q, 1-cycle latency).
- Classifies each RGB333 pixel as "marker colour" and counts hits per vertical key strip.
- Publishes a per-key pressed mask to the piano logic once per scan.

Parameters:
- NUM_KEYS, 8: number of key strips across the image.
- KEY_W, 20: columns per strip. NUM_KEYS*KEY_W must be ≤ 160.
- ROW_START, 80: first half-res row scanned (0..119).
- ROW_END, 119: last half-res row scanned (≥ ROW_START, ≤ 119).
- R_MIN, 5: pixel matches if q[8:6] ≥ R_MIN.
- G_MAX, 2: ...and q[5:3] ≤ G_MAX.
- B_MAX, 3: ...and q[2:0] ≤ B_MAX.
- THRESH, 40: hit count at or above which a key reads pressed.

Ports:
- clk  in  1  system clock; the same clock that drives the frame buffer read port.
- rst  in  1  synchronous, active-high reset.
- scan_req  in  1  one-cycle pulse requesting one scan.
- addr  out  32  frame-buffer read address: row y at [24:18], column x at [9:2], all other bits 0.
- q  in  9  pixel data {R[2:0],G[2:0],B[2:0]}, valid one cycle after addr.
- busy  out  1  high from scan accept until mask_valid.
- key_mask  out  NUM_KEYS  bit k=1 means key k is pressed.
- mask_valid  out  1  one-cycle pulse when key_mask has updated.
- debug_out  out  32  {8'd0, hit count of key 0 [11:0], scan counter [11:0]}.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, addr=0, busy=0, key_mask=0, mask_valid=0, all hit counters 0, scan counter 0, debug_out=0.
- States: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
- IDLE
  - On scan_req=1: clear all hit counters; set x=0, y=ROW_START, key index kx=0, sub-column sx=0; busy=1; go to SCAN.
  - scan_req is ignored in every other state (no queuing).
- SCAN
  - Each cycle drives addr from the current (x,y), then advances.
  - Column advance: x++ and sx++. When sx==KEY_W-1, set sx=0 and kx++.
  - When x==NUM_KEYS*KEY_W-1: x=0, kx=0, sx=0, y++.
  - After issuing the address (NUM_KEYS*KEY_W-1, ROW_END), go to FLUSH.
  - Columns at or beyond NUM_KEYS*KEY_W are never addressed.
- Pipeline: a registered copy of kx plus a valid bit accompanies each issued address. The cycle after issue, q is compared against the colour window; on a match, hit[kx_d] increments.
- Counters: 12-bit, saturating at 4095. Key index arithmetic uses counters only, no divider.
- FLUSH: accumulates the final pixel; addr holds its last value; go to DONE.
- DONE
  - key_mask[k] = (hit[k] ≥ THRESH), registered.
  - mask_valid=1 for exactly this one cycle; busy=0 at the same edge.
  - Scan counter increments, wrapping at 4095; return to IDLE.
- Latency: accepting scan_req at edge T gives mask_valid high in cycle T+N+2, where N=NUM_KEYS*KEY_W*(ROW_END-ROW_START+1). With defaults N=6400.
- key_mask holds its value between scans; it changes only in DONE.
- rst mid-scan: immediate return to IDLE with all reset values; no mask_valid is produced.
- scan_req arriving in the same cycle as DONE is ignored.

Optional Feature:
- Macro: CAM_KEY_SCAN_DEBOUNCE_EN.
- Defined:
  - A raw mask register stores each scan's threshold result.
  - key_mask[k] updates only when the raw bit from the current scan equals the raw bit from the previous scan.
  - Raw register resets to 0.
  - mask_valid still pulses every scan.
- Undefined: key_mask is the raw threshold result of the current scan; no raw history register exists.

Test Plan:
- Reset, then an all-zero frame buffer model and scan_req -> busy=1; mask_valid exactly 6402 cycles later; key_mask=0.
- Marker colour q=9'b111_000_000 filling columns 20..39 in rows 80..119 -> key_mask=8'b0000_0010. Same buffer with columns 20..39 limited to rows 80..81 (40 hits) -> bit 1 still set. With rows 80..80 only (20 hits) -> key_mask=0.
- Address check: the first three addr values are y=80, x=0,1,2 (addr=32'h0140_0000, 32'h0140_0004, 32'h0140_0008). The last addr is y=119, x=159 (32'h01DC_027C).
- scan_req pulsed again at cycle 100 of a scan -> ignored; exactly one mask_valid. After that, scan_req in IDLE starts a new scan.
- rst asserted for one cycle mid-scan -> next cycle busy=0, key_mask=0, addr=0; no mask_valid within 7000 cycles.
- With CAM_KEY_SCAN_DEBOUNCE_EN: key 3 marker present in scan 1 only -> key_mask[3]=0 after both scans. Marker present in scans 2 and 3 -> key_mask[3]=1 after scan 3.

Source files
------------

// File: rtl/cam_key_scan.sv
// cam_key_scan: scans a row band of the frame buffer, counts marker-colour pixels per key strip, publishes a pressed mask.
// Optional CAM_KEY_SCAN_DEBOUNCE_EN: a key bit changes only when two consecutive scans agree.
module cam_key_scan #(
  parameter int NUM_KEYS  = 8,
  parameter int KEY_W     = 20,
  parameter int ROW_START = 80,
  parameter int ROW_END   = 119,
  parameter int R_MIN     = 5,
  parameter int G_MAX     = 2,
  parameter int B_MAX     = 3,
  parameter int THRESH    = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_req,
  output logic [31:0]         addr,
  input  logic [8:0]          q,
  output logic                busy,
  output logic [NUM_KEYS-1:0] key_mask,
  output logic                mask_valid,
  output logic [31:0]         debug_out
);
  localparam int NCOL = NUM_KEYS * KEY_W;
  localparam int KXW  = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int SXW  = KEY_W > 1 ? $clog2(KEY_W) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [KXW-1:0] kx_q, kx_d, kx_p_q;
  logic [SXW-1:0] sx_q, sx_d;
  logic vld_q, mv_q, match, last_col, last_row, last_sx, start;
  logic [11:0] hit_q [NUM_KEYS];
  logic [11:0] cnt_q;
  logic [NUM_KEYS-1:0] mask_q, raw_d, mask_d;
  assign start    = state_q == IDLE && scan_req;
  assign last_col = x_q == 8'(NCOL - 1);
  assign last_row = y_q == 7'(ROW_END);
  assign last_sx  = sx_q == SXW'(KEY_W - 1);
  assign match    = q[8:6] >= 3'(R_MIN) && q[5:3] <= 3'(G_MAX) && q[2:0] <= 3'(B_MAX);
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    kx_d = kx_q;
    sx_d = sx_q;
    case (state_q)
      IDLE: if (scan_req) begin
        state_d = SCAN;
        x_d = '0;
        y_d = 7'(ROW_START);
        kx_d = '0;
        sx_d = '0;
      end
      SCAN: if (last_col && last_row) state_d = FLUSH;
      else if (last_col) begin
        x_d = '0;
        kx_d = '0;
        sx_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        sx_d = last_sx ? '0 : sx_q + 1'b1;
        kx_d = last_sx ? kx_q + 1'b1 : kx_q;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    raw_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) raw_d[k] = hit_q[k] >= 12'(THRESH);
  end
`ifdef CAM_KEY_SCAN_DEBOUNCE_EN
  logic [NUM_KEYS-1:0] raw_q;
  always_ff @(posedge clk)
    if (rst) raw_q <= '0;
    else if (state_q == DONE) raw_q <= raw_d;
  assign mask_d = (raw_d & ~(raw_d ^ raw_q)) | (mask_q & (raw_d ^ raw_q));
`else
  assign mask_d = raw_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      kx_q <= '0;
      sx_q <= '0;
      kx_p_q <= '0;
      vld_q <= 1'b0;
      mv_q <= 1'b0;
      mask_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      kx_q <= kx_d;
      sx_q <= sx_d;
      kx_p_q <= kx_q;
      vld_q <= state_q == SCAN;
      mv_q <= state_q == DONE;
      if (state_q == DONE) begin
        mask_q <= mask_d;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  // q belongs to the address issued last cycle, so it is credited to the delayed key index
  always_ff @(posedge clk)
    for (int k = 0; k < NUM_KEYS; k++)
      if (rst || start) hit_q[k] <= '0;
      else if (vld_q && match && kx_p_q == KXW'(k) && hit_q[k] != 12'hFFF) hit_q[k] <= hit_q[k] + 1'b1;
  assign addr       = {7'd0, y_q, 8'd0, x_q, 2'd0};
  assign busy       = state_q != IDLE;
  assign key_mask   = mask_q;
  assign mask_valid = mv_q;
  assign debug_out  = {8'd0, hit_q[0], cnt_q};
endmodule
